// File: rtl/bus_sched_pkg.sv
// bus_sched_pkg: shared state encoding and default timing constants for cpu_bus_scheduler
package bus_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, DMA = 2'd2} state_t;
  localparam int CYCLE_LEN_DEF = 8;
  localparam int RDY_LEAD_DEF = 3;
  localparam int PHASE_W = $clog2(CYCLE_LEN_DEF);
endpackage

// File: rtl/cycle_phase_counter.sv
// cycle_phase_counter: phase within the current CPU cycle, with boundary and cycle-start flags
module cycle_phase_counter import bus_sched_pkg::*; #(
  parameter int LEN = CYCLE_LEN_DEF,
  parameter int W = PHASE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_half,
  output logic [W-1:0] o_phase,
  output logic         o_boundary,
  output logic         o_cycle_start
);
  logic [W-1:0] r_phase;
  logic         r_start;
  assign o_phase = r_phase;
  assign o_cycle_start = r_start;
  assign o_boundary = r_phase == (i_half ? W'(LEN / 2 - 1) : W'(LEN - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      r_start <= 1'b1;
    end else begin
      r_phase <= o_boundary ? '0 : r_phase + 1'b1;
      r_start <= o_boundary;
    end
  end
endmodule

// File: rtl/cpu_bus_scheduler.sv
// cpu_bus_scheduler: CPU cycle sequencer and TED DMA arbiter; RDY leads AEC removal by RDY_LEAD cycles.
// Define BUS_SCHED_FAST_EN to add the fast port for half-length idle cycles.
module cpu_bus_scheduler import bus_sched_pkg::*; #(
  parameter int CYCLE_LEN = CYCLE_LEN_DEF,
  parameter int RDY_LEAD = RDY_LEAD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
`ifdef BUS_SCHED_FAST_EN
  input  logic fast,
`endif
  output logic cpu_enable,
  output logic gate_out,
  output logic aec,
  output logic rdy,
  output logic dma_grant,
  output logic cycle_start
);
  localparam int PW = $clog2(CYCLE_LEN);
  state_t          r_state, w_state_n;
  logic [2:0]      r_lead;
  logic [PW-1:0]   w_phase, w_ph_n;
  logic            w_bnd, w_half, w_half_n, w_gate_n, w_last_n;
  cycle_phase_counter #(.LEN(CYCLE_LEN), .W(PW)) u_phase (
    .clk(clk), .reset(reset), .i_half(w_half),
    .o_phase(w_phase), .o_boundary(w_bnd), .o_cycle_start(cycle_start)
  );
`ifdef BUS_SCHED_FAST_EN
  logic r_half;
  assign w_half = r_half;
  assign w_half_n = w_bnd ? (r_state == IDLE && !dma_req && fast) : r_half;
  always_ff @(posedge clk) r_half <= reset ? 1'b0 : w_half_n;
`else
  assign w_half = 1'b0;
  assign w_half_n = 1'b0;
`endif
  always_comb begin
    w_state_n = !w_bnd ? r_state :
                r_state == IDLE ? (dma_req ? STALL : IDLE) :
                !dma_req ? IDLE :
                (r_state == STALL && r_lead != 3'd0) ? STALL : DMA;
    w_ph_n = w_bnd ? '0 : w_phase + 1'b1;
    w_gate_n = w_ph_n < (w_half_n ? PW'(CYCLE_LEN / 4) : PW'(CYCLE_LEN / 2));
    w_last_n = w_ph_n == (w_half_n ? PW'(CYCLE_LEN / 2 - 1) : PW'(CYCLE_LEN - 1));
  end
  // outputs are loaded from next-tick values so they stay aligned with the phase they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_lead     <= 3'd0;
      cpu_enable <= 1'b0;
      gate_out   <= 1'b1;
      aec        <= 1'b1;
      rdy        <= 1'b1;
      dma_grant  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_lead     <= (w_bnd && r_state == IDLE) ? 3'(RDY_LEAD - 1) :
                    (w_bnd && r_state == STALL && r_lead != 3'd0) ? r_lead - 3'd1 : r_lead;
      cpu_enable <= w_last_n && w_state_n != DMA;
      gate_out   <= w_gate_n;
      aec        <= w_state_n != DMA;
      rdy        <= w_state_n == IDLE;
      dma_grant  <= w_state_n == DMA;
    end
  end
endmodule

// File: tb/tb_cpu_bus_scheduler.sv
// tb_cpu_bus_scheduler: directed and randomized checks against a request-streak model of the scheduler
module tb_cpu_bus_scheduler;
  localparam int CL = 8, RL = 3;
  logic clk = 1'b0, reset = 1'b1, dma_req = 1'b0;
`ifdef BUS_SCHED_FAST_EN
  logic fast = 1'b0;
`endif
  logic cpu_enable, gate_out, aec, rdy, dma_grant, cycle_start;
  int n_cmp = 0, n_err = 0;
  int t = 0, m_phase = 0, m_len = CL, m_streak = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cpu_bus_scheduler #(.CYCLE_LEN(CL), .RDY_LEAD(RL)) dut (
    .clk(clk), .reset(reset), .dma_req(dma_req),
`ifdef BUS_SCHED_FAST_EN
    .fast(fast),
`endif
    .cpu_enable(cpu_enable), .gate_out(gate_out), .aec(aec), .rdy(rdy),
    .dma_grant(dma_grant), .cycle_start(cycle_start)
  );

  // Model: the bus state follows from how many consecutive boundaries saw dma_req=1.
  always @(posedge clk) begin
    int prev;
    bit f;
`ifdef BUS_SCHED_FAST_EN
    f = fast;
`else
    f = 1'b0;
`endif
    if (reset) begin
      t = 0; m_phase = 0; m_len = CL; m_streak = 0;
    end else begin
      t++;
      if (m_phase == m_len - 1) begin
        prev = m_streak;
        m_streak = dma_req ? m_streak + 1 : 0;
        m_len = (prev == 0 && m_streak == 0 && f) ? CL / 2 : CL;
        m_phase = 0;
      end else m_phase++;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0d", name, act, exp, t);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    logic e_aec;
    e_aec = m_streak <= RL;
    check("m_aec", aec, e_aec);
    check("m_grant", dma_grant, !e_aec);
    check("m_rdy", rdy, m_streak == 0);
    check("m_cpu_enable", cpu_enable, (m_phase == m_len - 1) && e_aec);
    check("m_gate_out", gate_out, m_phase < m_len / 2);
    check("m_cycle_start", cycle_start, m_phase == 0);
  end

  task automatic wait_t(input int k);
    while (t < k) @(negedge clk);
  endtask

  initial begin
    int budget;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_aec", aec, 1'b1);
    check("rst_rdy", rdy, 1'b1);
    check("rst_gate", gate_out, 1'b1);
    check("rst_cs", cycle_start, 1'b1);
    check("rst_ce", cpu_enable, 1'b0);
    wait_t(3);  dma_req = 1'b1;
    wait_t(4);  check("gate_t4", gate_out, 1'b0);
    wait_t(7);  check("ce_t7", cpu_enable, 1'b1);
    wait_t(8);  check("rdy_t8", rdy, 1'b0);
    wait_t(15); check("ce_stall_t15", cpu_enable, 1'b1);
    wait_t(31); check("aec_t31", aec, 1'b1);
    wait_t(32); check("aec_t32", aec, 1'b0);
    check("grant_t32", dma_grant, 1'b1);
    wait_t(39); check("ce_dma_t39", cpu_enable, 1'b0);
    wait_t(42); dma_req = 1'b0;
    wait_t(47); check("aec_t47", aec, 1'b0);
    wait_t(48); check("aec_t48", aec, 1'b1);
    check("rdy_t48", rdy, 1'b1);
    wait_t(55); check("ce_t55", cpu_enable, 1'b1);
    dma_req = 1'b1;
    budget = 0;
    while (dma_grant !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
    check("grant_reached", dma_grant, 1'b1);
    reset = 1'b1;
    dma_req = 1'b0;
    @(negedge clk);
    check("rst_dma_aec", aec, 1'b1);
    check("rst_dma_rdy", rdy, 1'b1);
    check("rst_dma_grant", dma_grant, 1'b0);
    check("rst_dma_cs", cycle_start, 1'b1);
    reset = 1'b0;
    wait_t(2);  dma_req = 1'b1;
    wait_t(10); dma_req = 1'b0;
    wait_t(15); check("abort_rdy_t15", rdy, 1'b0);
    wait_t(16); check("abort_rdy_t16", rdy, 1'b1);
    check("abort_aec_t16", aec, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) dma_req = ~dma_req;
`ifdef BUS_SCHED_FAST_EN
      if ($urandom_range(0, 9) == 0) fast = ~fast;
`endif
    end
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
